lcd_cmd_issuer: RTL and testbench



---
 rtl/lcd_pkg.sv | 26 ++
 rtl/lcd_cmd_fifo.sv | 61 ++++++
 rtl/lcd_cmd_issuer.sv | 106 ++++++++++
 tb/tb_lcd_cmd_issuer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD image controller and its command issuer.
package lcd_pkg;

    typedef logic [2:0] cmd_t;

    // Command codes, shared with the controller
    localparam cmd_t WRTBK = 3'd0;
    localparam cmd_t OP_UP = 3'd1;
    localparam cmd_t OP_DN = 3'd2;
    localparam cmd_t OP_LF = 3'd3;
    localparam cmd_t OP_RT = 3'd4;
    localparam cmd_t AVRGE = 3'd5;
    localparam cmd_t MRR_X = 3'd6;
    localparam cmd_t MRR_Y = 3'd7;

    // Issuer sequencing states
    typedef enum logic [2:0] {
        WAIT_INIT,
        IDLE,
        ISSUE,
        GUARD,
        WBACK,
        FIN
    } issuer_state_e;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous FIFO holding host commands until the issuer pops them.
// Pointers wrap naturally because DEPTH is a power of two; occupancy is kept
// in a separate counter one bit wider so full and empty are unambiguous.
module lcd_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign dout    = mem_q[rd_ptr_q];
    // Guard against overflow/underflow even if the caller misbehaves
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next pointer and occupancy values
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates reads
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/lcd_cmd_issuer.sv
// Issues buffered host commands to the LCD controller one at a time,
// respecting its busy flag, and locks after a write-back completes.
module lcd_cmd_issuer
    import lcd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              host_cmd,
    input  logic                    host_valid,
    output logic                    host_ready,
    input  logic                    busy,
    input  logic                    done,
    output logic [2:0]              cmd,
    output logic                    cmd_valid,
    output logic [$clog2(DEPTH):0]  fifo_cnt,
    output logic [CNT_W-1:0]        issued_cnt,
    output logic                    seq_done
);

    issuer_state_e    state_q, state_d;
    cmd_t             cmd_q, cmd_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic             seq_done_q, seq_done_d;

    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    cmd_t             fifo_dout;

    // Once a write-back is outstanding or finished, the host is shut out
    assign host_ready = !fifo_full && (state_q != WBACK) && (state_q != FIN);
    assign fifo_push  = host_valid && host_ready;

    lcd_cmd_fifo #(
        .DEPTH (DEPTH),
        .DW    (3)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (host_cmd),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    // Sequencer: next state, pop decision and next output register values
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        issued_d    = issued_q;
        seq_done_d  = seq_done_q;
        fifo_pop    = 1'b0;
        case (state_q)
            WAIT_INIT: if (!busy) state_d = IDLE;
            IDLE: begin
                if (!fifo_empty && !busy) begin
                    fifo_pop    = 1'b1;
                    cmd_d       = fifo_dout;
                    cmd_valid_d = 1'b1;
                    issued_d    = issued_q + CNT_W'(1);
                    state_d     = ISSUE;
                end
            end
            ISSUE:  state_d = (cmd_q == WRTBK) ? WBACK : GUARD;
            // One dead cycle lets the controller raise busy before we look again
            GUARD:  state_d = IDLE;
            WBACK: begin
                if (done) begin
                    state_d    = FIN;
                    seq_done_d = 1'b1;
                end
            end
            FIN:     seq_done_d = 1'b1;
            default: state_d = WAIT_INIT;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= WAIT_INIT;
            cmd_q       <= WRTBK;
            cmd_valid_q <= 1'b0;
            issued_q    <= '0;
            seq_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            issued_q    <= issued_d;
            seq_done_q  <= seq_done_d;
        end
    end

    assign cmd        = cmd_q;
    assign cmd_valid  = cmd_valid_q;
    assign issued_cnt = issued_q;
    assign seq_done   = seq_done_q;

endmodule

// File: tb/tb_lcd_cmd_issuer.sv
// Scoreboard bench for lcd_cmd_issuer: the stimulus side queues the commands
// that must come out in order, a monitor pops and compares every issue pulse.
module tb_lcd_cmd_issuer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [2:0]             host_cmd;
    logic                   host_valid;
    logic                   host_ready;
    logic                   busy;
    logic                   done;
    logic [2:0]             cmd;
    logic                   cmd_valid;
    logic [$clog2(DEPTH):0] fifo_cnt;
    logic [CNT_W-1:0]       issued_cnt;
    logic                   seq_done;

    lcd_cmd_issuer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .host_cmd   (host_cmd),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .busy       (busy),
        .done       (done),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .fifo_cnt   (fifo_cnt),
        .issued_cnt (issued_cnt),
        .seq_done   (seq_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [2:0] exp_q[$];     // commands that must be issued, in order
    int         pulse_cyc[$]; // cycle stamps of observed issue pulses
    int         n_iss = 0;    // issues since reset, per the model
    int         last_pulse = -100;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: every issue pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (reset) begin
            n_iss      = 0;
            last_pulse = -100;
        end else if (cmd_valid) begin
            n_iss++;
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", int'(cmd), -1);
            end else begin
                chk("issue_cmd", int'(cmd), int'(exp_q.pop_front()));
            end
            chk("issued_cnt", int'(issued_cnt), n_iss % (1 << CNT_W));
            if (last_pulse >= 0 && cyc - last_pulse < 3)
                chk("issue_rate_gap", cyc - last_pulse, 3);
            pulse_cyc.push_back(cyc);
            last_pulse = cyc;
        end
    end

    // One host cycle; optionally offers a command and queues it as expected
    task automatic host_cycle(input logic v, input logic [2:0] c, input logic add);
        host_valid = v;
        host_cmd   = c;
        @(negedge clk);
        if (v) chk("host_ready_on_push", int'(host_ready), 1);
        @(posedge clk);
        if (v && add) exp_q.push_back(c);
        #1;
        host_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        exp_q.delete();
        #1;
        reset = 1'b0;
        pulse_cyc.delete();
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout_left", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int k = 0;
        while (pulse_cyc.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("pulse_count", pulse_cyc.size(), n);
    endtask

    task automatic check_gaps(input string name);
        for (int i = 1; i < pulse_cyc.size(); i++)
            chk(name, pulse_cyc[i] - pulse_cyc[i-1], 3);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] c;
        logic [2:0] seq3[3];
        int         k;
        int         bad;
        logic       prev_hr;

        reset = 1'b1; host_valid = 1'b0; host_cmd = '0; busy = 1'b1; done = 1'b0;

        // Reset values
        do_reset(2);
        @(negedge clk);
        chk("rst_cmd_valid", int'(cmd_valid), 0);
        chk("rst_cmd", int'(cmd), 0);
        chk("rst_fifo_cnt", int'(fifo_cnt), 0);
        chk("rst_issued_cnt", int'(issued_cnt), 0);
        chk("rst_seq_done", int'(seq_done), 0);
        chk("rst_host_ready", int'(host_ready), 1);
        @(posedge clk); #1;

        // Controller loading: nothing issues while busy, then 4,1,5 spaced by 3
        seq3[0] = 3'd4; seq3[1] = 3'd1; seq3[2] = 3'd5;
        for (int i = 0; i < 70; i++) begin
            if (i == 10 || i == 20 || i == 30) host_cycle(1'b1, seq3[i/10 - 1], 1'b1);
            else host_cycle(1'b0, 3'd0, 1'b0);
        end
        chk("init_no_issue", pulse_cyc.size(), 0);
        chk("init_fifo_cnt", int'(fifo_cnt), 3);
        busy = 1'b0;
        wait_pulses(3, 30);
        check_gaps("init_gap");
        chk("init_issued_cnt", int'(issued_cnt), 3);
        wait_drain(10);

        // Fill to DEPTH under busy, reject the extra offer, then drain
        busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) host_cycle(1'b1, 3'($urandom_range(1, 7)), 1'b1);
        @(negedge clk);
        chk("full_fifo_cnt", int'(fifo_cnt), DEPTH);
        chk("full_host_ready", int'(host_ready), 0);
        @(posedge clk); #1;
        host_valid = 1'b1; host_cmd = 3'd7;
        @(posedge clk); #1;
        host_valid = 1'b0;
        @(negedge clk);
        chk("full_no_push", int'(fifo_cnt), DEPTH);
        @(posedge clk); #1;
        pulse_cyc.delete();
        busy = 1'b0;
        k = 0; prev_hr = host_ready;
        while (!cmd_valid && k < 20) begin
            @(negedge clk);
            if (!cmd_valid) prev_hr = host_ready;
            k++;
        end
        chk("ready_before_pop", int'(prev_hr), 0);
        chk("ready_after_pop", int'(host_ready), 1);
        chk("cnt_after_pop", int'(fifo_cnt), DEPTH - 1);
        wait_drain(60);
        check_gaps("drain_gap");

        // Back-to-back pushes with busy low: push and pop coincide
        pulse_cyc.delete();
        for (int i = 0; i < 6; i++) host_cycle(1'b1, 3'($urandom_range(0, 7) | 1), 1'b1);
        wait_pulses(6, 40);
        check_gaps("stream_gap");
        wait_drain(10);

        // busy rises as the FIFO becomes non-empty: issue waits for busy low
        host_cycle(1'b1, 3'd2, 1'b1);
        busy = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (cmd_valid) bad++;
        end
        chk("busy_defer_no_issue", bad, 0);
        chk("busy_defer_cnt", int'(fifo_cnt), 1);
        @(posedge clk); #1;
        busy = 1'b0;
        @(negedge clk);
        chk("busy_defer_still_quiet", int'(cmd_valid), 0);
        @(negedge clk);
        chk("busy_defer_issue", int'(cmd_valid), 1);
        chk("busy_defer_cmd", int'(cmd), 2);
        wait_drain(10);

        // Random traffic with random busy; outstanding kept below DEPTH
        for (int i = 0; i < 300; i++) begin
            busy = ($urandom_range(0, 3) == 0);
            c = 3'($urandom_range(1, 7));
            if ($urandom_range(0, 1) == 1 && exp_q.size() < DEPTH - 2)
                host_cycle(1'b1, c, 1'b1);
            else
                host_cycle(1'b0, c, 1'b0);
        end
        busy = 1'b0;
        wait_drain(60);

        // Write-back: MIRROR_X, WRTBK issue; LEFT stays queued forever
        host_cycle(1'b1, 3'd6, 1'b1);
        host_cycle(1'b1, 3'd0, 1'b1);
        host_cycle(1'b1, 3'd3, 1'b0);
        k = 0;
        while (!(cmd_valid && cmd == 3'd0) && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("wrtbk_seen", int'(cmd_valid && cmd == 3'd0), 1);
        busy = 1'b1;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (host_ready || cmd_valid || seq_done) bad++;
        end
        chk("wback_locked", bad, 0);
        @(posedge clk); #1;
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        @(negedge clk);
        chk("fin_seq_done", int'(seq_done), 1);
        chk("fin_fifo_cnt", int'(fifo_cnt), 1);
        chk("fin_host_ready", int'(host_ready), 0);
        busy = 1'b0;
        repeat (10) @(negedge clk);
        chk("fin_hold", int'(seq_done), 1);
        chk("fin_left_kept", int'(fifo_cnt), 1);

        // Reset while in WBACK with three entries queued behind the write-back
        @(posedge clk); #1;
        busy = 1'b1;
        do_reset(1);
        for (int i = 0; i < 4; i++) host_cycle(1'b1, 3'(i), i == 0);
        busy = 1'b0;
        k = 0;
        while (!cmd_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk("wback2_fifo_cnt", int'(fifo_cnt), 3);
        chk("wback2_host_ready", int'(host_ready), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_fifo_cnt", int'(fifo_cnt), 0);
        chk("mid_rst_cmd_valid", int'(cmd_valid), 0);
        chk("mid_rst_seq_done", int'(seq_done), 0);
        chk("mid_rst_host_ready", int'(host_ready), 1);
        chk("mid_rst_issued", int'(issued_cnt), 0);
        repeat (5) @(negedge clk);
        chk("mid_rst_quiet", int'(cmd_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
